shooting_flags_rx: RTL

//  Receive end of the LED "shooting" display. Samples the 8 PWM-dimmed LED cathode lines
//  (one ASCII byte per symbol period) and strips the PWM. Recovers each displayed byte,

---
 rtl/shooting_flags_rx_if.sv | 45 ++++
 rtl/shooting_flags_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shooting_flags_rx_if.sv
// shooting_flags_rx_if
//  Bundles the cathode input, byte/frame status outputs and the buffer read
//  port of the shooting-display receiver.
//  Modports:
//   master : drives cats and rd_addr, observes everything else (controller / bench)
//   slave  : the receiver itself
//  Signals:
//   cats [7:0]          LED cathode lines, active-high, PWM-gated
//   byte_data [7:0]     last accepted byte
//   byte_valid          1-cycle strobe, byte_data is new
//   frame_active        high while capturing between '{' and '}'
//   frame_done          1-cycle strobe on '}'
//   frame_len [AW:0]    length of last completed frame, braces excluded
//   overflow            1-cycle strobe, buffer depth exceeded
//   rd_addr [AW-1:0]    buffer read address
//   rd_data [7:0]       buffer data, 1-cycle latency
//   crc [7:0]           CRC-8 of last completed frame (0 when CRC is not built)
interface shooting_flags_rx_if #(
  parameter int MAX_LEN = 48
) ();
  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]    cats;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          frame_active;
  logic          frame_done;
  logic [AW:0]   frame_len;
  logic          overflow;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    crc;

  modport master (
    output cats, rd_addr,
    input  byte_data, byte_valid, frame_active, frame_done, frame_len,
           overflow, rd_data, crc
  );

  modport slave (
    input  cats, rd_addr,
    output byte_data, byte_valid, frame_active, frame_done, frame_len,
           overflow, rd_data, crc
  );
endinterface

// File: rtl/shooting_flags_rx.sv
// shooting_flags_rx
//  Loop-back receiver for the LED "shooting" display. Strips the PWM from
//  the 8 cathode lines with a windowed OR envelope, recovers each displayed
//  byte (including doubled characters) and frames the text between '{' and
//  '}' into a readable buffer.
//  Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    shooting_flags_rx_if.slave (cats, rd_addr in; byte/frame status,
//          rd_data and crc out)
//  Optional feature: define SHOOTING_RX_CRC_EN to compute a CRC-8
//  (poly 0x07, init 0x00, MSB first) over each captured frame; otherwise
//  crc is tied to zero.
module shooting_flags_rx #(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int PWM_WIN    = 8,
  parameter int SYMBOL_WIN = CLK_FREQ / 2 / PWM_WIN,
  parameter int STABLE_WIN = SYMBOL_WIN / 4,
  parameter int MAX_LEN    = 48
) (
  input logic               clk,
  input logic               rst_n,
  shooting_flags_rx_if.slave bus
);
  localparam int AW     = $clog2(MAX_LEN);
  localparam int LW     = AW + 1;
  localparam int CNT_W  = $clog2(PWM_WIN);
  localparam int STAB_W = $clog2(STABLE_WIN + 1);
  localparam int REP_W  = $clog2(SYMBOL_WIN);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PWM_WIN - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_WIN);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_WIN - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(SYMBOL_WIN - 1);
  localparam logic [LW-1:0]     LEN_MAX  = LW'(MAX_LEN);
  localparam logic [7:0]        LBRACE   = 8'h7B;
  localparam logic [7:0]        RBRACE   = 8'h7D;

  // ---------------- envelope: OR of cats over each PWM window ------------
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       acc_reg;
  logic [7:0]       env_reg;
  logic             win_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      env_reg  <= '0;
      win_tick <= 1'b0;
    end else begin
      win_tick <= 1'b0;
      if (cnt_reg == CNT_LAST) begin
        cnt_reg  <= '0;
        env_reg  <= acc_reg | bus.cats;
        acc_reg  <= '0;
        win_tick <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        acc_reg <= acc_reg | bus.cats;
      end
    end
  end

  // ---------------- symbol stage: debounce and repeat recovery ----------
  logic [7:0]        cand_reg;
  logic [7:0]        last_acc_reg;
  logic [STAB_W-1:0] stab_reg;
  logic [REP_W-1:0]  rep_reg;
  logic [7:0]        byte_data_reg;
  logic              byte_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg       <= '0;
      last_acc_reg   <= '0;
      stab_reg       <= '0;
      rep_reg        <= '0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      if (win_tick) begin
        if (env_reg != cand_reg) begin
          cand_reg <= env_reg;
          stab_reg <= '0;
          rep_reg  <= '0;
        end else begin
          if (stab_reg != STAB_MAX)
            stab_reg <= stab_reg + 1'b1;
          if (cand_reg == 8'h00) begin
            // A blank gap separates two identical symbols, so forget the last one.
            last_acc_reg <= '0;
            rep_reg      <= '0;
          end else if (stab_reg == STAB_PRE && cand_reg != last_acc_reg) begin
            byte_data_reg  <= cand_reg;
            byte_valid_reg <= 1'b1;
            last_acc_reg   <= cand_reg;
            rep_reg        <= '0;
          end else if (cand_reg == last_acc_reg) begin
            // Same byte held for a full symbol period means it was shown twice.
            if (rep_reg == REP_LAST) begin
              byte_data_reg  <= cand_reg;
              byte_valid_reg <= 1'b1;
              rep_reg        <= '0;
            end else begin
              rep_reg <= rep_reg + 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- framer FSM -------------------------------------------
  typedef enum logic [0:0] {HUNT, CAPTURE} state_t;
  state_t state_reg, state_next;

  logic          start_frame, end_frame, store_byte, over_flag, frame_active;
  logic [LW-1:0] wptr_reg;
  logic [LW-1:0] frame_len_reg;
  logic          frame_done_reg;
  logic          overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= HUNT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_frame)
      state_next = CAPTURE;
    else if (end_frame || over_flag)
      state_next = HUNT;
  end

  always_comb begin
    start_frame  = 1'b0;
    end_frame    = 1'b0;
    store_byte   = 1'b0;
    over_flag    = 1'b0;
    frame_active = (state_reg == CAPTURE);
    if (byte_valid_reg) begin
      case (state_reg)
        HUNT:    start_frame = (byte_data_reg == LBRACE);
        CAPTURE: begin
          if (byte_data_reg == RBRACE)      end_frame   = 1'b1;
          else if (byte_data_reg == LBRACE) start_frame = 1'b1;
          else if (wptr_reg == LEN_MAX)     over_flag   = 1'b1;
          else                              store_byte  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg       <= '0;
      frame_len_reg  <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      frame_done_reg <= end_frame;
      overflow_reg   <= over_flag;
      if (start_frame)
        wptr_reg <= '0;
      else if (store_byte)
        wptr_reg <= wptr_reg + 1'b1;
      if (end_frame)
        frame_len_reg <= wptr_reg;
    end
  end

`ifdef SHOOTING_RX_CRC_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  logic [7:0] crc_run_reg;
  logic [7:0] crc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run_reg <= '0;
      crc_reg     <= '0;
    end else begin
      if (start_frame)
        crc_run_reg <= '0;
      else if (store_byte)
        crc_run_reg <= crc8_step(crc_run_reg, byte_data_reg);
      if (end_frame)
        crc_reg <= crc_run_reg;
    end
  end

  assign bus.crc = crc_reg;
`else
  assign bus.crc = 8'h00;
`endif

  // ---------------- frame buffer -----------------------------------------
  // Storage has no reset so it maps onto block RAM; only the read register resets.
  logic [7:0] mem [0:MAX_LEN-1];
  logic [7:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (store_byte)
      mem[wptr_reg[AW-1:0]] <= byte_data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data_reg <= '0;
    else if ({1'b0, bus.rd_addr} < LEN_MAX)
      rd_data_reg <= mem[bus.rd_addr];
    else
      rd_data_reg <= '0;
  end

  assign bus.byte_data    = byte_data_reg;
  assign bus.byte_valid   = byte_valid_reg;
  assign bus.frame_active = frame_active;
  assign bus.frame_done   = frame_done_reg;
  assign bus.frame_len    = frame_len_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.rd_data      = rd_data_reg;
endmodule
